// File: rtl/box_plotter.sv
// Rectangle rasteriser for the VGA adapter pixel port: draws a clipped box or
// clears the screen, one registered pixel per clock, with busy/done/abort.
module box_plotter #(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int C_W       = 3,
  parameter int DIM_W     = 4,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int BG_COLOUR = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             mode,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [DIM_W-1:0] w_in,
  input  logic [DIM_W-1:0] h_in,
  input  logic [C_W-1:0]   colour_in,
  input  logic             abort,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [C_W-1:0]   colour,
  output logic             plot,
  output logic             busy,
  output logic             done
);

  // Counters must hold both a full-screen clear and the largest encoded box.
  localparam int DIM_MAX = 2 ** DIM_W;
  localparam int W_MAX   = (SCREEN_W > DIM_MAX) ? SCREEN_W : DIM_MAX;
  localparam int H_MAX   = (SCREEN_H > DIM_MAX) ? SCREEN_H : DIM_MAX;
  localparam int CX_W    = $clog2(W_MAX + 1);
  localparam int CY_W    = $clog2(H_MAX + 1);
  localparam int SX_W    = X_W + 1;
  localparam int SY_W    = Y_W + 1;

  localparam logic [CX_W-1:0] W_FULL   = CX_W'(DIM_MAX);
  localparam logic [CY_W-1:0] H_FULL   = CY_W'(DIM_MAX);
  localparam logic [CX_W-1:0] W_SCREEN = CX_W'(SCREEN_W);
  localparam logic [CY_W-1:0] H_SCREEN = CY_W'(SCREEN_H);
  localparam logic [SX_W-1:0] X_LIMIT  = SX_W'(SCREEN_W);
  localparam logic [SY_W-1:0] Y_LIMIT  = SY_W'(SCREEN_H);
  localparam logic [C_W-1:0]  BG       = C_W'(BG_COLOUR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [X_W-1:0]  x0_q, x0_d;
  logic [Y_W-1:0]  y0_q, y0_d;
  logic [CX_W-1:0] w_q, w_d;
  logic [CY_W-1:0] h_q, h_d;
  logic [CX_W-1:0] col_q, col_d;
  logic [CY_W-1:0] row_q, row_d;
  logic [C_W-1:0]  fill_q, fill_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [C_W-1:0]  colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [SX_W-1:0] sum_x_s;
  logic [SY_W-1:0] sum_y_s;
  logic            clip_s;
  logic            last_col_s;
  logic            last_row_s;

  // Pixel address one bit wider than the port so overflow clips instead of wrapping.
  always_comb begin
    sum_x_s    = SX_W'(x0_q) + SX_W'(col_q);
    sum_y_s    = SY_W'(y0_q) + SY_W'(row_q);
    clip_s     = (sum_x_s >= X_LIMIT) || (sum_y_s >= Y_LIMIT);
    last_col_s = (col_q == (w_q - CX_W'(1)));
    last_row_s = (row_q == (h_q - CY_W'(1)));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    row_d    = row_q;
    fill_d   = fill_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRAW;
          col_d   = '0;
          row_d   = '0;
          if (mode) begin
            x0_d   = '0;
            y0_d   = '0;
            w_d    = W_SCREEN;
            h_d    = H_SCREEN;
            fill_d = BG;
          end else begin
            x0_d   = x_in;
            y0_d   = y_in;
            w_d    = (w_in == '0) ? W_FULL : CX_W'(w_in);
            h_d    = (h_in == '0) ? H_FULL : CY_W'(h_in);
            fill_d = colour_in;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DRAW: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          x_d      = sum_x_s[X_W-1:0];
          y_d      = sum_y_s[Y_W-1:0];
          colour_d = fill_q;
          plot_d   = ~clip_s;
          busy_d   = 1'b1;
          if (last_col_s) begin
            col_d = '0;
            if (last_row_s) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + CY_W'(1);
            end
          end else begin
            col_d = col_q + CX_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (abort) begin
          done_d = 1'b0;
          busy_d = 1'b0;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // State, operand and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      fill_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fill_q   <= fill_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_box_plotter.sv
// Directed plus randomized bench for box_plotter; expected pixels come from a
// row/column enumeration of the requested rectangle with screen-bound clipping.
module tb_box_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       mode;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [3:0] w_in;
  logic [3:0] h_in;
  logic [2:0] colour_in;
  logic       abort;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  box_plotter dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in),
    .colour_in(colour_in), .abort(abort),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_px(input string tag, input logic [20:0] exp);
    logic [20:0] obs;
    obs = {x, y, colour, plot, busy, done};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed {x,y,c,plot,busy,done}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {plot, busy, done};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed {plot,busy,done}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick;
      chk_ctl("idle", 3'b000);
    end
  endtask

  // Issue one request and follow it pixel by pixel; optionally disturb it.
  task automatic run_box(input int bx, input int by, input int bw, input int bh,
                         input int bc, input int bmode, input int noise,
                         input int abort_after, input int rst_after,
                         input int abort_at_start);
    int ex0, ey0, ew, eh, ec, n, px, py;
    logic [20:0] e;
    x_in = 8'(bx); y_in = 7'(by); w_in = 4'(bw); h_in = 4'(bh);
    colour_in = 3'(bc); mode = 1'(bmode); start = 1'b1;
    abort = (abort_at_start != 0);
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk_ctl("start_latency", 3'b000);
    if (bmode != 0) begin
      ex0 = 0; ey0 = 0; ew = 160; eh = 120; ec = 0;
    end else begin
      ex0 = bx; ey0 = by; ec = bc;
      ew = (bw == 0) ? 16 : bw;
      eh = (bh == 0) ? 16 : bh;
    end
    n = ew * eh;
    for (int i = 0; i < n; i++) begin
      if (noise != 0) begin
        start = 1'b1; mode = 1'($urandom); x_in = 8'($urandom); y_in = 7'($urandom);
        w_in = 4'($urandom); h_in = 4'($urandom); colour_in = 3'($urandom);
      end
      tick;
      px = ex0 + (i % ew);
      py = ey0 + (i / ew);
      e = {8'(px), 7'(py), 3'(ec), (px < 160 && py < 120), 1'b1, 1'b0};
      chk_px("pixel", e);
      if (abort_after == i + 1) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        chk_ctl("abort", 3'b000);
        return;
      end
      if (rst_after == i + 1) begin
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        start = 1'b0;
        chk_px("reset_mid", 21'd0);
        return;
      end
    end
    start = 1'b0;
    tick;
    chk_ctl("done_pulse", 3'b011);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    x_in = 8'd0; y_in = 7'd0; w_in = 4'd0; h_in = 4'd0; colour_in = 3'd0;
    tick;
    tick;
    chk_px("reset", 21'd0);
    resetn = 1'b1;
    idle_chk(1);

    // basic 4x4 box
    run_box(10, 20, 4, 4, 5, 0, 0, 0, 0, 0);
    idle_chk(2);
    // clipping at bottom-right corner
    run_box(158, 119, 4, 2, 3, 0, 0, 0, 0, 0);
    idle_chk(1);
    // zero width encodes 16
    run_box(0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
    idle_chk(1);
    // clear screen ignores box operands
    run_box(37, 5, 3, 9, 7, 1, 0, 0, 0, 0);
    idle_chk(1);
    // start noise during DRAW must not change the box
    run_box(50, 60, 4, 4, 2, 0, 1, 0, 0, 0);
    idle_chk(1);
    // abort at pixel 6, no done afterwards, then a normal box
    run_box(20, 30, 4, 4, 1, 0, 0, 6, 0, 0);
    idle_chk(3);
    run_box(21, 31, 3, 2, 4, 0, 0, 0, 0, 0);
    idle_chk(1);
    // reset mid-draw, then a complete box
    run_box(100, 100, 5, 3, 4, 0, 0, 0, 3, 0);
    idle_chk(1);
    run_box(100, 100, 5, 3, 4, 0, 0, 0, 0, 0);
    // back-to-back: next start sampled at the edge leaving the done cycle
    run_box(5, 6, 2, 3, 7, 0, 0, 0, 0, 0);
    idle_chk(1);
    // abort together with start in IDLE: start wins
    run_box(70, 80, 3, 3, 6, 0, 0, 0, 0, 1);
    idle_chk(1);

    for (int r = 0; r < 25; r++) begin
      run_box(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)), 0, int'($urandom_range(0, 1)), 0, 0, 0);
      idle_chk(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
